// File: rtl/full_adder_pkg.sv
// Shared constants and golden reference for the ripple-carry full adder.
package full_adder_pkg;

  localparam int WIDTH_MAX = 64;

  // Golden a + b + cin over the widest legal operand. The result is
  // WIDTH_MAX+1 bits wide. Callers zero-extend narrower operands, so the
  // carry out of a WIDTH-bit add appears at bit [WIDTH].
  function automatic logic [WIDTH_MAX:0] add_ref(
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{WIDTH_MAX{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full-adder cell: the leaf of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;

  // The propagate term is shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from WIDTH fa_cells, with an optional
// one-cycle output register and a matching valid flag.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH out of range 1..64");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_c;

  assign c[0] = cin;

  // The ripple chain: bit i's carry out feeds bit i+1's carry in.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s_c[i]),
      .co  (c[i+1])
    );
  end

  logic [WIDTH_MAX-1:0] a_ext, b_ext;
  assign a_ext = WIDTH_MAX'(a);
  assign b_ext = WIDTH_MAX'(b);

  // Cross-check the chain against the golden adder while the inputs are known.
  always_comb begin
    if (!$isunknown({a, b, cin}))
      assert (add_ref(a_ext, b_ext, cin) == (WIDTH_MAX+1)'({c[WIDTH], s_c}))
        else $error("full_adder: ripple chain disagrees with add_ref");
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             vld_q;

    assign sum_d  = s_c;
    assign cout_d = c[WIDTH];

    // Capture on valid, hold otherwise. Reset beats a coincident valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= in_valid;
        if (in_valid) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
        end
      end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    assign sum       = s_c;
    assign cout      = c[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench: 1-bit and 4-bit registered adders, and an 8-bit combinational adder.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1, registered
  logic       a1, b1, cin1, iv1, cout1, ov1;
  logic [0:0] sum1;
  // WIDTH=4, registered
  logic [3:0] a4, b4, sum4;
  logic       cin4, iv4, cout4, ov4;
  // WIDTH=8, combinational
  logic [7:0] a8, b8, sum8;
  logic       cin8, iv8, cout8, ov8;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cout(cout1), .sum(sum1), .a(a1), .b(b1),
    .cin(cin1), .in_valid(iv1), .out_valid(ov1));

  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) dut4 (
    .clk(clk), .rst(rst), .cout(cout4), .sum(sum4), .a(a4), .b(b4),
    .cin(cin4), .in_valid(iv4), .out_valid(ov4));

  full_adder #(.WIDTH(8), .REG_OUT(1'b0)) dut8 (
    .clk(clk), .rst(rst), .cout(cout8), .sum(sum8), .a(a8), .b(b8),
    .cin(cin8), .in_valid(iv8), .out_valid(ov8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0]  exp9;
    logic [64:0] r;
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a4 = 0; b4 = 0; cin4 = 0; iv4 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;

    // Reset state
    tick();
    chk("w1 reset {ov,cout,sum}", {ov1, cout1, sum1}, 3'b000);
    chk("w4 reset {ov,cout,sum}", {ov4, cout4, sum4}, 6'b000000);

    // WIDTH=1 truth-table points
    rst = 1'b0; iv1 = 1'b1;
    {a1, b1, cin1} = 3'b000; tick(); chk("w1 000", {ov1, cout1, sum1}, 3'b100);
    {a1, b1, cin1} = 3'b100; tick(); chk("w1 100", {ov1, cout1, sum1}, 3'b101);
    {a1, b1, cin1} = 3'b011; tick(); chk("w1 011", {ov1, cout1, sum1}, 3'b110);
    {a1, b1, cin1} = 3'b111; tick(); chk("w1 111", {ov1, cout1, sum1}, 3'b111);
    {a1, b1, cin1} = 3'b010; tick(); chk("w1 010", {ov1, cout1, sum1}, 3'b101);

    // Reset held two cycles with valid inputs present: reset wins
    {a1, b1, cin1} = 3'b111; rst = 1'b1;
    tick(); chk("w1 rst hold 1", {ov1, cout1, sum1}, 3'b000);
    tick(); chk("w1 rst hold 2", {ov1, cout1, sum1}, 3'b000);
    rst = 1'b0;
    tick(); chk("w1 first after rst", {ov1, cout1, sum1}, 3'b111);
    iv1 = 1'b0;
    tick(); chk("w1 idle hold", {ov1, cout1, sum1}, 3'b011);

    // WIDTH=4 wrap-around cases
    iv4 = 1'b1;
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; tick();
    chk("w4 F+0+1", {ov4, cout4, sum4}, {2'b11, 4'h0});
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0; tick();
    chk("w4 7+8+0", {ov4, cout4, sum4}, {2'b10, 4'hF});
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; tick();
    chk("w4 F+F+1", {ov4, cout4, sum4}, {2'b11, 4'hF});
    a4 = 4'h5; b4 = 4'hA; cin4 = 1'b1; tick();
    chk("w4 5+A+1", {ov4, cout4, sum4}, {2'b11, 4'h0});

    // Valid gap: result holds while inputs churn
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; tick();
    chk("w4 3+4", {ov4, cout4, sum4}, {2'b10, 4'h7});
    iv4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a4 = 4'(k + 9); b4 = 4'(2 * k + 6); cin4 = 1'(k);
      tick();
      chk($sformatf("w4 gap %0d", k), {ov4, cout4, sum4}, {2'b00, 4'h7});
    end

    // Reset on the same edge as a valid 5+6: the 11 must never surface
    iv4 = 1'b1; a4 = 4'h5; b4 = 4'h6; cin4 = 1'b0; rst = 1'b1;
    tick(); chk("w4 rst mid-stream", {ov4, cout4, sum4}, 6'b000000);
    rst = 1'b0; iv4 = 1'b0;
    tick(); chk("w4 after discard", {ov4, cout4, sum4}, 6'b000000);
    iv4 = 1'b1; a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0;
    tick(); chk("w4 9+9 after rst", {ov4, cout4, sum4}, {2'b11, 4'h2});
    iv4 = 1'b0;

    // WIDTH=8 combinational: exhaustive low nibbles, with in_valid toggling
    for (int i = 0; i < 512; i++) begin
      a8 = 8'(i[3:0]); b8 = 8'(i[7:4]); cin8 = i[8]; iv8 = i[0] ^ i[5];
      #1;
      exp9 = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
      chk($sformatf("w8 nib %0d", i), {ov8, cout8, sum8}, {iv8, exp9});
    end
    // Full-width random vectors, also cross-checking the package reference
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'($urandom);
      #1;
      exp9 = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
      chk($sformatf("w8 rnd %0d", i), {ov8, cout8, sum8}, {iv8, exp9});
      r = add_ref(64'(a8), 64'(b8), cin8);
      chk($sformatf("w8 add_ref %0d", i), r[8:0], exp9);
    end
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; iv8 = 1'b1; #1;
    chk("w8 FF+FF+1", {ov8, cout8, sum8}, {2'b11, 8'hFF});
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; iv8 = 1'b0; #1;
    chk("w8 80+80", {ov8, cout8, sum8}, {2'b01, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered ripple-carry full adder: computes a + b + cin over WIDTH bits and presents {cout, sum} one clock after valid inputs are accepted.
- Default WIDTH=1 gives the classic single-bit full adder used as the arithmetic leaf in combinational/datapath blocks.
- Wider instances serve as small accumulator/incrementer datapaths.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational, and clk/rst/in_valid are ignored except for out_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cout  output  1  carry out of MSB.
- sum  output  WIDTH  sum bits, (a+b+cin) mod 2^WIDTH.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in to LSB.
- in_valid  input  1  qualifies a/b/cin.
- out_valid  output  1  qualifies cout/sum.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Port order of the data ports is cout, sum, a, b, cin, matching the existing instantiation convention; clk, rst, in_valid and out_valid are connected by name.
- Arithmetic:
  - {cout, sum} = a + b + cin, computed as a WIDTH-bit ripple chain of 1-bit cells.
  - Per cell: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin; cout = c_WIDTH.
  - No overflow flag; wrap-around is modulo 2^WIDTH, with the carry reported on cout.
- REG_OUT=1:
  - On each rising clk edge with rst=1: sum=0, cout=0, out_valid=0.
  - On each rising clk edge with rst=0 and in_valid=1: capture the combinational result into sum/cout, and set out_valid=1.
  - On each rising clk edge with rst=0 and in_valid=0: sum/cout hold their last value, and out_valid=0.
  - Latency is exactly 1 cycle. Throughput is one result per cycle, with no backpressure.
  - Reset asserted mid-stream discards the in-flight result. The first valid after reset deasserts produces output on the following edge.
  - rst and in_valid both high: reset wins.
- REG_OUT=0:
  - sum/cout follow a/b/cin combinationally, with no latches.
  - out_valid = in_valid combinationally.
- X-handling: no reset of input paths is required; outputs after reset are never X.

Decomposition:
- Shared package full_adder_pkg:
  - WIDTH_MAX = 64 constant.
  - A function add_ref(a, b, cin) returning the WIDTH+1-bit golden sum, used by both RTL assertions and the bench.
- One sub-module, fa_cell: a 1-bit combinational full-adder cell (inputs a, b, cin; outputs s, co). It is instantiated WIDTH times via generate to form the ripple chain.
- The top level holds the chain wiring, the output register and the valid pipeline.

Test Plan:
- WIDTH=1, REG_OUT=1, reset then in_valid=1 with sequence (a,b,cin) = (0,0,0), (1,0,0), (0,1,1), (1,1,1) -> one cycle after each, {cout,sum} = 00, 01, 10, 11, with out_valid=1.
- Reset check: hold rst=1 for 2 cycles with in_valid=1, a=b=cin=1 -> sum=0, cout=0, out_valid=0 throughout. On the first edge after rst falls, {cout,sum}=11 one cycle later.
- WIDTH=4 wrap: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1. Then a=4'h7, b=4'h8, cin=0 -> sum=4'hF, cout=0. Then a=b=4'hF, cin=1 -> sum=4'hF, cout=1.
- in_valid gaps: valid with a=3, b=4, then in_valid=0 for 3 cycles with changing a/b -> sum stays 7, out_valid=0 during the gap.
- Reset mid-stream: in_valid=1 with a=5, b=6, and rst=1 on the same edge -> sum=0, cout=0, out_valid=0. The result 11 never appears.
- REG_OUT=0, WIDTH=8: exhaustive on low 4 bits plus random full-width vectors -> {cout,sum} equals add_ref immediately, and out_valid mirrors in_valid.
